// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues one bus request per load/store, stalls the
// upstream pipeline while the request is outstanding, times out after 16
// unacknowledged cycles and hands a one-cycle result to the MEM/WB register.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic [3:0]  i_wb_dst,
  input  logic [15:0] i_alu_result,
  input  logic [15:0] i_wdata,
  input  logic        i_flush,
  output logic        o_mreq,
  output logic        o_mwe,
  output logic [15:0] o_maddr,
  output logic [15:0] o_mwdata,
  input  logic        i_mack,
  input  logic [15:0] i_mrdata,
  output logic        o_valid,
  output logic        o_mem_to_reg,
  output logic [3:0]  o_wb_dst,
  output logic [15:0] o_mem_data,
  output logic [15:0] o_alu_result,
  output logic        o_stall,
  output logic        o_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          squash_q, squash_d;
  logic          err_q, err_d;

  logic [DW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic [RW-1:0] lat_dst_q, lat_dst_d;
  logic          lat_m2r_q, lat_m2r_d;
  logic          lat_we_q, lat_we_d;

  logic          valid_q, valid_d;
  logic          m2r_q, m2r_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [DW-1:0] mdata_q, mdata_d;
  logic [DW-1:0] alu_q, alu_d;

  logic          accept_c;
  logic          fin_c;
  logic [DW-1:0] fin_data_c;

  assign accept_c = (state_q == IDLE) && i_valid && !i_flush && (i_mem_read || i_mem_write);

  // Next-state, latch and result computation; result outputs default to zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    squash_d    = squash_q;
    err_d       = err_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_dst_d   = lat_dst_q;
    lat_m2r_d   = lat_m2r_q;
    lat_we_d    = lat_we_q;
    valid_d     = 1'b0;
    m2r_d       = 1'b0;
    dst_d       = '0;
    mdata_d     = '0;
    alu_d       = '0;
    fin_c       = 1'b0;
    fin_data_c  = '0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          lat_addr_d  = i_alu_result;
          lat_wdata_d = i_wdata;
          lat_dst_d   = i_wb_dst;
          lat_m2r_d   = i_mem_to_reg;
          lat_we_d    = i_mem_write;
          cnt_d       = '0;
          squash_d    = 1'b0;
          state_d     = REQ;
        end else if (i_valid && !i_flush) begin
          valid_d = 1'b1;
          alu_d   = i_alu_result;
          dst_d   = i_wb_dst;
          m2r_d   = i_mem_to_reg;
        end
      end
      REQ: begin
        // A flush cannot abort the bus cycle; it only squashes the result.
        if (i_flush) squash_d = 1'b1;
        if (i_mack) begin
          fin_c      = 1'b1;
          fin_data_c = lat_we_q ? '0 : i_mrdata;
          state_d    = DONE;
        end else if (cnt_q == CW'(15)) begin
          fin_c   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin_c && !(squash_q || i_flush)) begin
      valid_d = 1'b1;
      alu_d   = lat_addr_q;
      dst_d   = lat_dst_q;
      m2r_d   = lat_m2r_q;
      mdata_d = fin_data_c;
    end
  end

  // State, latched request and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      squash_q    <= 1'b0;
      err_q       <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_dst_q   <= '0;
      lat_m2r_q   <= 1'b0;
      lat_we_q    <= 1'b0;
      valid_q     <= 1'b0;
      m2r_q       <= 1'b0;
      dst_q       <= '0;
      mdata_q     <= '0;
      alu_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      squash_q    <= squash_d;
      err_q       <= err_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_dst_q   <= lat_dst_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_we_q    <= lat_we_d;
      valid_q     <= valid_d;
      m2r_q       <= m2r_d;
      dst_q       <= dst_d;
      mdata_q     <= mdata_d;
      alu_q       <= alu_d;
    end
  end

  // Bus signals decode directly from the state register.
  assign o_mreq   = (state_q == REQ);
  assign o_mwe    = o_mreq && lat_we_q;
  assign o_maddr  = o_mreq ? lat_addr_q : '0;
  assign o_mwdata = o_mreq ? lat_wdata_q : '0;

  assign o_stall      = accept_c || (state_q == REQ);
  assign o_err        = err_q;
  assign o_valid      = valid_q;
  assign o_mem_to_reg = m2r_q;
  assign o_wb_dst     = dst_q;
  assign o_mem_data   = mdata_q;
  assign o_alu_result = alu_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed operations push expected
// results; a negedge monitor pops and compares whenever o_valid is seen.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mem_read, i_mem_write, i_mem_to_reg, i_flush, i_mack;
  logic [3:0]  i_wb_dst;
  logic [15:0] i_alu_result, i_wdata, i_mrdata;
  logic        o_mreq, o_mwe, o_valid, o_mem_to_reg, o_stall, o_err;
  logic [15:0] o_maddr, o_mwdata, o_mem_data, o_alu_result;
  logic [3:0]  o_wb_dst;

  typedef struct packed {
    logic [3:0]  dst;
    logic        m2r;
    logic [15:0] mdata;
    logic [15:0] alu;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg), .i_wb_dst(i_wb_dst),
    .i_alu_result(i_alu_result), .i_wdata(i_wdata), .i_flush(i_flush),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mwdata(o_mwdata),
    .i_mack(i_mack), .i_mrdata(i_mrdata), .o_valid(o_valid),
    .o_mem_to_reg(o_mem_to_reg), .o_wb_dst(o_wb_dst), .o_mem_data(o_mem_data),
    .o_alu_result(o_alu_result), .o_stall(o_stall), .o_err(o_err)
  );

  // Monitor: every presented result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      total++;
      mon_a = '{dst: o_wb_dst, m2r: o_mem_to_reg, mdata: o_mem_data, alu: o_alu_result, err: o_err};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got dst=%0d alu=%h data=%h, required no output",
                 o_wb_dst, o_alu_result, o_mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL result got dst=%0d m2r=%0d data=%h alu=%h err=%0d, required dst=%0d m2r=%0d data=%h alu=%h err=%0d",
                   mon_a.dst, mon_a.m2r, mon_a.mdata, mon_a.alu, mon_a.err,
                   mon_e.dst, mon_e.m2r, mon_e.mdata, mon_e.alu, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
    i_flush = 1'b0; i_mack = 1'b0; i_wb_dst = '0; i_alu_result = '0;
    i_wdata = '0; i_mrdata = '0;
  endtask

  // Non-memory instruction: result appears the next cycle without stalling.
  task automatic pass(input string nm, input logic [15:0] alu, input logic [3:0] dst,
                      input logic m2r, input logic exp_e);
    exp_t x;
    i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_alu_result = alu; i_wb_dst = dst; i_mem_to_reg = m2r; i_flush = 1'b0;
    x = '{dst: dst, m2r: m2r, mdata: 16'h0000, alu: alu, err: exp_e};
    exp_q.push_back(x);
    @(negedge clk);
    chk({nm, "_stall"}, 32'(o_stall), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk({nm, "_stall_after"}, 32'(o_stall), 32'd0);
    tick();
  endtask

  // Load/store: ack_at is the REQ cycle carrying i_mack (0 = never), flush_at
  // the REQ cycle carrying i_flush (0 = never).
  task automatic mem_op(input string nm, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rdat, input logic [3:0] dst, input logic m2r,
                        input int ack_at, input int flush_at, input logic exp_v,
                        input logic exp_e, input logic [15:0] exp_md, input int exp_n);
    int   n, st, badc;
    logic done;
    exp_t x;
    n = 0; st = 0; badc = 0; done = 1'b0;
    if (exp_v) begin
      x = '{dst: dst, m2r: m2r, mdata: exp_md, alu: addr, err: exp_e};
      exp_q.push_back(x);
    end
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_alu_result = addr;
    i_wdata = wd; i_wb_dst = dst; i_mem_to_reg = m2r; i_flush = 1'b0; i_mack = 1'b0;
    @(negedge clk);
    if (o_stall) st++;
    chk({nm, "_idle_mreq"}, 32'(o_mreq), 32'd0);
    tick();
    for (int c = 1; c <= 24 && !done; c++) begin
      i_mack = (c == ack_at); i_mrdata = rdat; i_flush = (c == flush_at);
      @(negedge clk);
      if (o_stall) st++;
      if (o_mreq) begin
        n++;
        if (o_maddr !== addr || o_mwe !== wr || o_mwdata !== wd) badc++;
      end else begin
        done = 1'b1;
        chk({nm, "_done_valid"}, 32'(o_valid), 32'(exp_v));
        chk({nm, "_done_err"}, 32'(o_err), 32'(exp_e));
        idle_inputs();
      end
      tick();
    end
    chk({nm, "_finished"}, 32'(done), 32'd1);
    chk({nm, "_req_cycles"}, 32'(n), 32'(exp_n));
    chk({nm, "_stall_cycles"}, 32'(st), 32'(exp_n + 1));
    chk({nm, "_bus_fields"}, 32'(badc), 32'd0);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_mreq", 32'(o_mreq), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_mem_data", 32'(o_mem_data), 32'd0);
    chk("rst_alu", 32'(o_alu_result), 32'd0);
    rst = 1'b0;
    tick();

    pass("pass1", 16'h1234, 4'd5, 1'b0, 1'b0);
    mem_op("load", 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 4'd3, 1'b1,
           3, 0, 1'b1, 1'b0, 16'hBEEF, 3);
    mem_op("store", 1'b0, 1'b1, 16'h0010, 16'h00FF, 16'hAAAA, 4'd0, 1'b0,
           1, 0, 1'b1, 1'b0, 16'h0000, 1);
    mem_op("rdwr", 1'b1, 1'b1, 16'h0022, 16'h5A5A, 16'h7777, 4'd7, 1'b1,
           2, 0, 1'b1, 1'b0, 16'h0000, 2);
    pass("pass2", 16'hFFFF, 4'd15, 1'b1, 1'b0);
    mem_op("flush_req", 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h1111, 4'd9, 1'b1,
           4, 2, 1'b0, 1'b0, 16'h0000, 4);
    mem_op("timeout", 1'b1, 1'b0, 16'h00F0, 16'h0000, 16'h2222, 4'd2, 1'b1,
           0, 0, 1'b1, 1'b1, 16'h0000, 16);
    @(negedge clk);
    chk("err_sticky", 32'(o_err), 32'd1);
    tick();
    pass("pass_err", 16'h0001, 4'd1, 1'b0, 1'b1);

    // Flush while presented in IDLE: nothing accepted.
    i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 16'h0044; i_flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 32'(o_stall), 32'd0);
    chk("flush_idle_mreq", 32'(o_mreq), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("flush_idle_mreq_next", 32'(o_mreq), 32'd0);
    chk("flush_idle_valid_next", 32'(o_valid), 32'd0);
    tick();

    // Reset in the middle of a request; a late ack must be ignored.
    i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 16'h0066; i_wb_dst = 4'd4;
    tick();
    @(negedge clk);
    chk("rstreq_mreq_before", 32'(o_mreq), 32'd1);
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    i_mack = 1'b1; i_mrdata = 16'h9999;
    @(negedge clk);
    chk("rstreq_mreq", 32'(o_mreq), 32'd0);
    chk("rstreq_stall", 32'(o_stall), 32'd0);
    chk("rstreq_valid", 32'(o_valid), 32'd0);
    chk("rstreq_err", 32'(o_err), 32'd0);
    chk("rstreq_maddr", 32'(o_maddr), 32'd0);
    chk("rstreq_mem_data", 32'(o_mem_data), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rstreq_late_ack_valid", 32'(o_valid), 32'd0);
    tick();

    pass("pass_recover", 16'h0BAD, 4'd6, 1'b0, 1'b0);
    repeat (2) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
